// File: rtl/seq_chunk_comparator_if.sv
// Start/done handshake and operand/result bundle for the chunked comparator.
interface seq_chunk_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    // Upstream controller: issues requests, consumes results.
    modport master (
        output start, signed_mode, a, b,
        input  busy, done, eq, gt, lt
    );

    // Comparator: accepts requests, produces results.
    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/seq_chunk_comparator.sv
// Sequential WIDTH-bit equality/magnitude comparator. Walks the operands
// CHUNK bits per clock from the most-significant chunk down and stops at the
// first chunk that differs. Two's-complement ordering is obtained by flipping
// the sign bit of the top chunk, which turns the signed order into unsigned.
module seq_chunk_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                  clk,
    input logic                  rst,
    seq_chunk_comparator_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COMPARE = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             smode_q;
    logic [KW-1:0]    k;
    logic             busy_r;
    logic             done_r;
    logic             eq_r;
    logic             gt_r;
    logic             lt_r;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             flip;

    // Chunk idx of v counted from the MSB end; optionally invert its top bit.
    function automatic logic [CHUNK-1:0] chunk_sel(
        input logic [WIDTH-1:0] v,
        input logic [KW-1:0]    idx,
        input logic             inv
    );
        logic [WIDTH-1:0] sh;
        logic [CHUNK-1:0] c;
        sh = v << (int'(idx) * CHUNK);
        c  = sh[WIDTH-1 -: CHUNK];
        if (inv) c[CHUNK-1] = ~c[CHUNK-1];
        return c;
    endfunction

    // Current chunk pair, sign-corrected only on the MSB chunk in signed mode.
    always_comb begin
        flip = smode_q && (k == '0);
        ca   = chunk_sel(a_q, k, flip);
        cb   = chunk_sel(b_q, k, flip);
    end

    // Control FSM, operand latch and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            smode_q <= 1'b0;
            k       <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            eq_r    <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        smode_q <= bus.signed_mode;
                        k       <= '0;
                        busy_r  <= 1'b1;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (ca != cb) begin
                        eq_r   <= 1'b0;
                        gt_r   <= (ca > cb);
                        lt_r   <= (ca < cb);
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (k == K_LAST) begin
                        eq_r   <= 1'b1;
                        gt_r   <= 1'b0;
                        lt_r   <= 1'b0;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.eq   = eq_r;
    assign bus.gt   = gt_r;
    assign bus.lt   = lt_r;
endmodule

// File: tb/tb_seq_chunk_comparator.sv
// Bench for seq_chunk_comparator (WIDTH=16, CHUNK=4): table of directed
// vectors, model-checked random vectors, and hand-written multi-cycle cases.
module tb_seq_chunk_comparator;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sm;
        int               lat;
        logic             eq;
        logic             gt;
        logic             lt;
    } vec_t;

    typedef struct {
        int   lat;
        logic eq;
        logic gt;
        logic lt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];

    seq_chunk_comparator_if #(.WIDTH(WIDTH)) bus();

    seq_chunk_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count done pulses independently of the test sequences.
    always begin
        @(posedge clk);
        #1;
        if (bus.done) done_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: first differing chunk sets latency; magnitude from plain compare.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sm);
        exp_t e;
        logic found;
        e.lat = NCHUNK;
        found = 1'b0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (!found && (a[WIDTH-1-i*CHUNK -: CHUNK] != b[WIDTH-1-i*CHUNK -: CHUNK])) begin
                e.lat = i + 1;
                found = 1'b1;
            end
        end
        e.eq = (a == b);
        e.gt = sm ? ($signed(a) > $signed(b)) : (a > b);
        e.lt = sm ? ($signed(a) < $signed(b)) : (a < b);
        return e;
    endfunction

    // Count edges after the start edge until done; lat=-1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 2 * NCHUNK + 2; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    // Pop the scoreboard and compare against the observed completion.
    task automatic score(input string name, input int lat);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({name, " sb_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check({name, " latency"}, lat, e.lat);
        check({name, " eq"}, int'(bus.eq), int'(e.eq));
        check({name, " gt"}, int'(bus.gt), int'(e.gt));
        check({name, " lt"}, int'(bus.lt), int'(e.lt));
        check({name, " busy_at_done"}, int'(bus.busy), 0);
    endtask

    // Drive one request from idle, push expectation, wait, score.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic sm, input exp_t e);
        int lat;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.signed_mode = sm;
        bus.start = 1'b1;
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        bus.start = 1'b0;
        check({name, " busy"}, int'(bus.busy), 1);
        wait_done(lat);
        score(name, lat);
    endtask

    vec_t vecs[12];

    initial begin
        exp_t e;
        int lat;
        int d0;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rs;

        vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'hA000, 16'h9FFF, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h12F4, 16'h12F5, 1'b0, 4, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'hFFFE, 1'b1, 4, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'h0005, 16'h0003, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{16'h0100, 16'h0200, 1'b0, 2, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{16'h7FFF, 16'h8000, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 4, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'h00F0, 16'h0080, 1'b1, 3, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'hF000, 16'hE000, 1'b1, 1, 1'b0, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a = '0;
        bus.b = '0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        check("rst eq", int'(bus.eq), 0);
        check("rst gt", int'(bus.gt), 0);
        check("rst lt", int'(bus.lt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle no done", done_cnt, 0);

        // Directed table
        foreach (vecs[i]) begin
            e.lat = vecs[i].lat;
            e.eq  = vecs[i].eq;
            e.gt  = vecs[i].gt;
            e.lt  = vecs[i].lt;
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, e);
        end

        // Random vectors, half with only one chunk differing
        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 2 == 0) ? WIDTH'($urandom)
                              : ra ^ (WIDTH'($urandom_range(0, 15)) << (CHUNK * $urandom_range(0, NCHUNK-1)));
            rs = 1'(i % 3 == 0);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs));
        end

        // Start while busy is ignored; operand changes after latch have no effect
        d0 = done_cnt;
        @(negedge clk);
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(16'h0000, 16'h0000, 1'b0));
        @(negedge clk);
        bus.a = 16'hFFFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        // Two edges already elapsed since the start edge
        wait_done(lat);
        score("busy_start", (lat < 0) ? lat : lat + 2);
        repeat (6) @(negedge clk);
        check("busy_start one done", done_cnt - d0, 1);
        check("busy_start idle", int'(bus.busy), 0);

        // Asynchronous reset during the second compare cycle
        check("pre_rst eq held", int'(bus.eq), 1);
        d0 = done_cnt;
        @(negedge clk);
        bus.a = 16'h1111;
        bus.b = 16'h1111;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst busy", int'(bus.busy), 0);
        check("arst done", int'(bus.done), 0);
        check("arst eq", int'(bus.eq), 0);
        check("arst gt", int'(bus.gt), 0);
        check("arst lt", int'(bus.lt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("arst no done", done_cnt - d0, 0);
        e.lat = 4; e.eq = 1'b0; e.gt = 1'b1; e.lt = 1'b0;
        run_op("post_rst", 16'h0005, 16'h0003, 1'b0, e);

        // Back-to-back: start held high through the done cycle
        d0 = done_cnt;
        @(negedge clk);
        bus.a = 16'hA000;
        bus.b = 16'h9FFF;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(16'hA000, 16'h9FFF, 1'b0));
        @(negedge clk);
        bus.a = 16'h0100;
        bus.b = 16'h0200;
        wait_done(lat);
        score("b2b first", lat);
        @(posedge clk);
        sb_q.push_back(model(16'h0100, 16'h0200, 1'b0));
        #1;
        check("b2b busy again", int'(bus.busy), 1);
        check("b2b done low", int'(bus.done), 0);
        bus.start = 1'b0;
        wait_done(lat);
        score("b2b second", lat);
        repeat (3) @(negedge clk);
        check("b2b two dones", done_cnt - d0, 2);
        check("sb drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
